vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, frame-memory address width.
REQ-002 SHALL have parameter DATA_W, default 24, pixel width (RGB888).
REQ-003 SHALL have parameter FRAME_PIX, default 307200, pixels per frame (640x480).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, pixel prefetch FIFO entries (power of 2).
REQ-005 Port: clk  in  1  pixel clock.
REQ-006 Port: rstn  in  1  reset; asynchronous, active-low.
REQ-007 Port: vs  in  1  vertical sync from the timing generator, active high; a rising edge marks frame start.
REQ-008 Port: pix_req  in  1  active-video strobe (timing generator blank/valid); consumes one pixel per cycle.
REQ-009 Port: pix_data  out  DATA_W  pixel to the timing generator Signal input.
REQ-010 Port: underflow  out  1  sticky: pix_req seen with FIFO empty.
REQ-011 Port: wr_req / wr_addr / wr_data  in  1/ADDR_W/DATA_W  image-processing write request; held stable until granted.
REQ-012 Port: wr_gnt  out  1  write accepted this cycle.
REQ-013 Port: mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  single-port frame-memory command.
REQ-014 Port: mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read command.

Function
REQ-015 Memory SHALL carry at most one command per cycle; display reads and writer writes arbitrated.
REQ-016 FSM states: WAIT_VS (no fetch), FETCH (display reads allowed), DONE (frame fully fetched).
REQ-017 Reset -> WAIT_VS; vs rising edge (vs=1, previous vs=0) from any state -> FETCH, rd_addr=0, FIFO flushed.
REQ-018 FETCH -> DONE in the cycle rd_addr issues address FRAME_PIX-1; DONE holds until next vs rising edge.
REQ-019 Display read SHALL issue when state=FETCH and (FIFO count + in-flight read) < FIFO_DEPTH; rd_addr then increments.
REQ-020 Display read SHALL have strict priority; wr_gnt=1 iff wr_req=1 and no display read issued this cycle.
REQ-021 On grant: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, same cycle, combinational.
REQ-022 On display read: mem_en=1, mem_we=0, mem_addr=rd_addr, mem_wdata=0; idle cycle: all mem outputs 0.
REQ-023 mem_rdata SHALL be pushed into FIFO on the cycle after the read, unless a vs rising edge occurred in that cycle (in-flight data discarded).
REQ-024 FIFO is show-ahead; pix_data = FIFO head when pix_req=1 and FIFO non-empty, else 0.
REQ-025 pix_req=1 with FIFO non-empty pops one entry; simultaneous push and pop SHALL keep count unchanged.
REQ-026 pix_req=1 with FIFO empty: pix_data=0, no pop, underflow set to 1 next edge.
REQ-027 underflow SHALL remain 1 until reset; vs edges do not clear it.
REQ-028 rd_addr SHALL never exceed FRAME_PIX-1; no wrap inside a frame.
REQ-029 pix_req during WAIT_VS or after a flush SHALL be treated per REQ-026.

Reset
REQ-030 On rstn=0: state=WAIT_VS, rd_addr=0, FIFO empty, in-flight flag 0, vs history 0, underflow=0.
REQ-031 During reset: pix_data=0, wr_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-frame SHALL discard any in-flight read; no FIFO push after release.

Structure
REQ-033 Shared package SHALL hold FSM state enum and default constants FRAME_PIX, FIFO_DEPTH, ADDR_W, DATA_W.
REQ-034 FIFO SHALL be a sub-module sync_fifo (show-ahead, flush input, count output).

Verification
REQ-035 Reset release, vs held 0, wr_req=1 -> wr_gnt=1 every cycle, no reads, underflow=0.
REQ-036 vs rise, pix_req=0, wr_req=1 -> 16 reads at addr 0..15 in 16 consecutive cycles, wr_gnt=0 during them, then wr_gnt=1.
REQ-037 Steady active video, pix_req 640 of every 800 cycles -> pix_data sequence equals mem contents 0,1,2..., underflow stays 0.
REQ-038 pix_req=1 one cycle after vs rise -> pix_data=0, underflow=1 next cycle and held.
REQ-039 vs rise on the cycle after a read to addr 100 -> that data not pushed; next read addr 0; FIFO count 0 then refills.
REQ-040 FRAME_PIX=32 -> last read addr 31, state DONE, all later cycles grant writer until next vs rise.

Source files
------------

// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and default geometry for the VGA frame-memory arbiter.
// The sizing helper keeps FIFO counter widths consistent across modules.
package vga_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_VS = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam int DEF_ADDR_W     = 19;
   localparam int DEF_DATA_W     = 24;
   localparam int DEF_FRAME_PIX  = 307200;
   localparam int DEF_FIFO_DEPTH = 16;

   // Counter must hold the value DEPTH itself, hence one extra bit.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vga_mem_arbiter_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
// The head entry is visible on o_head whenever the FIFO is non-empty.
module sync_fifo
   import vga_mem_arbiter_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_FIFO_DEPTH,
   localparam int CNT_W  = cnt_w(DEPTH),
   localparam int PTR_W  = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_empty,
   output logic [CNT_W-1:0]  o_count
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = i_push & ~w_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   // Flush wins over a same-cycle push or pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame-memory arbiter: display prefetch reads with strict
// priority over image-processing writes, feeding a show-ahead pixel FIFO.
module vga_mem_arbiter
   import vga_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FRAME_PIX  = DEF_FRAME_PIX,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              vs,
   input  logic              pix_req,
   output logic [DATA_W-1:0] pix_data,
   output logic              underflow,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int              CNT_W     = cnt_w(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
   localparam logic [CNT_W:0]  DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

   state_t            r_state;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_inflight;
   logic              r_vs_d;
   logic              r_underflow;

   logic              w_vs_rise;
   logic              w_rd;
   logic              w_gnt;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W:0]    w_occ;
   logic [DATA_W-1:0] w_head;

   assign w_vs_rise = vs & ~r_vs_d;

   // Occupancy includes the read whose data lands next cycle, so the FIFO never overflows.
   assign w_occ  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_rd   = (r_state == ST_FETCH) & ~w_vs_rise & (w_occ < DEPTH_C);
   assign w_gnt  = rstn & wr_req & ~w_rd;
   assign w_push = r_inflight & ~w_vs_rise;
   assign w_pop  = pix_req & ~w_empty;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_rd) begin
         mem_en   = 1'b1;
         mem_addr = r_rd_addr;
      end else if (w_gnt) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end
   end

   assign wr_gnt    = w_gnt;
   assign pix_data  = w_pop ? w_head : '0;
   assign underflow = r_underflow;

   // The last address of a frame is issued once; rd_addr parks there until the next vs edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_WAIT_VS;
         r_rd_addr   <= '0;
         r_inflight  <= 1'b0;
         r_vs_d      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_vs_d     <= vs;
         r_inflight <= w_rd;
         if (pix_req && w_empty) r_underflow <= 1'b1;
         if (w_vs_rise) begin
            r_state   <= ST_FETCH;
            r_rd_addr <= '0;
         end else if (w_rd) begin
            if (r_rd_addr == LAST_ADDR) r_state   <= ST_DONE;
            else                        r_rd_addr <= r_rd_addr + 1'b1;
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_flush (w_vs_rise),
      .i_push  (w_push),
      .i_data  (mem_rdata),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: a large-frame instance checked every cycle against
// a transaction-level prefetch model, plus a 32-pixel instance for end-of-frame.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

   localparam int AW    = 19;
   localparam int DW    = 24;
   localparam int FPB   = 1536;
   localparam int FPS   = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          vs = 1'b0;
   logic          pix_req = 1'b0;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] pix_b, wdata_b, rdata_b;
   logic [DW-1:0] pix_s, wdata_s, rdata_s;
   logic [AW-1:0] addr_b, addr_s;
   logic          uf_b, gnt_b, en_b, we_b;
   logic          uf_s, gnt_s, en_s, we_s;

   always #5 clk = ~clk;

   vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIX(FPB), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rstn(rstn), .vs(vs), .pix_req(pix_req), .pix_data(pix_b), .underflow(uf_b),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(gnt_b),
      .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b));

   vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIX(FPS), .FIFO_DEPTH(DEPTH)) u_small (
      .clk(clk), .rstn(rstn), .vs(vs), .pix_req(pix_req), .pix_data(pix_s), .underflow(uf_s),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(gnt_s),
      .mem_en(en_s), .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s), .mem_rdata(rdata_s));

   // Frame-memory contents: a fixed pattern; the writer only targets addresses beyond the frame.
   function automatic logic [DW-1:0] pat(input int a);
      logic [31:0] h;
      h = a * 32'h9E3779B1 + 32'h01234567;
      return h[31:8];
   endfunction

   logic [DW-1:0] mem [2048];

   always @(posedge clk) begin
      if (en_b && !we_b) rdata_b <= mem[addr_b[10:0]];
      if (en_b && we_b)  mem[addr_b[10:0]] <= wdata_b;
      if (en_s && !we_s) rdata_s <= pat(int'(addr_s));
   end

   int ntot = 0;
   int npass = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   bit            m_fetch, m_infl, m_vsp, m_uf;
   int            m_next, popped;
   logic [DW-1:0] m_infl_val;
   logic [DW-1:0] m_q [$];
   bit            gnt_seen;
   int            last_rd_addr;
   logic [DW-1:0] last_pix;
   int            wr_mode;
   int            s_next, s_reads, s_idle, s_last_addr, s_last_rd;
   bit            s_vsp;

   task automatic model_reset();
      m_fetch = 0; m_infl = 0; m_vsp = 0; m_uf = 0; m_next = 0;
      m_q.delete();
      s_vsp = 0; s_next = 0;
   endtask

   task automatic monitor();
      bit            rise, exp_rd, pop, s_rd;
      logic [DW-1:0] exp_pix;
      last_pix     = pix_b;
      last_rd_addr = (en_b && !we_b) ? int'(addr_b) : -1;
      if (!rstn) begin
         chk("rst_pix", 32'(pix_b), 0);
         chk("rst_gnt", 32'(gnt_b), 0);
         chk("rst_en", 32'(en_b), 0);
         chk("rst_we", 32'(we_b), 0);
         chk("rst_addr", 32'(addr_b), 0);
         chk("rst_wdata", 32'(wdata_b), 0);
         chk("rst_uf", 32'(uf_b), 0);
         gnt_seen = 0;
         model_reset();
         return;
      end
      rise   = vs && !m_vsp;
      exp_rd = m_fetch && !rise && (m_q.size() + int'(m_infl) < DEPTH);
      chk("underflow", 32'(uf_b), 32'(m_uf));
      chk("rd_issue", 32'(en_b && !we_b), 32'(exp_rd));
      if (exp_rd) begin
         chk("rd_addr", 32'(addr_b), m_next);
         chk("rd_wdata", 32'(wdata_b), 0);
         chk("rd_gnt", 32'(gnt_b), 0);
      end else begin
         chk("wr_gnt", 32'(gnt_b), 32'(wr_req));
         chk("wr_en", 32'(en_b), 32'(wr_req));
         chk("wr_we", 32'(we_b), 32'(wr_req));
         chk("wr_addr", 32'(addr_b), wr_req ? 32'(wr_addr) : 0);
         chk("wr_wdata", 32'(wdata_b), wr_req ? 32'(wr_data) : 0);
      end
      pop     = pix_req && (m_q.size() > 0);
      exp_pix = pop ? m_q[0] : '0;
      chk("pix_data", 32'(pix_b), 32'(exp_pix));
      if (pix_req && m_q.size() == 0) m_uf = 1;
      gnt_seen = gnt_b;
      if (rise) begin
         m_q.delete();
         m_infl  = 0;
         m_fetch = 1;
         m_next  = 0;
      end else begin
         if (pop) begin
            void'(m_q.pop_front());
            popped++;
         end
         if (m_infl) m_q.push_back(m_infl_val);
         m_infl     = exp_rd;
         m_infl_val = pat(m_next);
         if (exp_rd) begin
            if (m_next == FPB - 1) m_fetch = 0;
            else                   m_next++;
         end
      end
      m_vsp = vs;
      // 32-pixel instance: sequential reads, never past the last pixel, writer otherwise granted
      s_rd      = en_s && !we_s;
      s_last_rd = s_rd ? int'(addr_s) : -1;
      if (s_rd) begin
         chk("s_rd_addr", 32'(addr_s), s_next);
         chk("s_rd_range", 32'(int'(addr_s) < FPS), 1);
         s_last_addr = int'(addr_s);
         s_next++;
         s_reads++;
         s_idle = 0;
      end else begin
         chk("s_gnt", 32'(gnt_s), 32'(wr_req));
         s_idle++;
      end
      if (vs && !s_vsp) s_next = 0;
      s_vsp = vs;
   endtask

   task automatic new_wr();
      wr_addr = AW'($urandom_range(FPB, 2047));
      wr_data = DW'($urandom);
   endtask

   task automatic drive_writer();
      if (wr_mode == 0) wr_req = 1'b0;
      else if (wr_mode == 1) begin
         wr_req = 1'b1;
         if (gnt_seen) new_wr();
      end else if (gnt_seen || !wr_req) begin
         wr_req = 1'($urandom_range(0, 1));
         new_wr();
      end
   endtask

   task automatic cyc();
      #2;
      monitor();
      @(posedge clk);
      #1;
      drive_writer();
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 2048; i++) mem[i] = pat(i);
      rdata_b = '0;
      rdata_s = '0;
      s_reads = 0; s_idle = 0; s_last_addr = -1; s_last_rd = -1;
      popped = 0;
      model_reset();
      new_wr();
      wr_mode = 1;
      wr_req  = 1'b1;

      // Reset: all outputs quiet even with a pending write
      @(posedge clk); #1;
      cyc(); cyc();
      rstn = 1'b1;

      // No vs yet: writer owns the memory every cycle
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk("p35_gnt", 32'(gnt_seen), 1);
      end

      // Frame start with no pixel demand: 16 back-to-back prefetch reads
      vs = 1'b1;
      cyc();
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk("p36_rd_addr", 32'(last_rd_addr), i);
         chk("p36_gnt_low", 32'(gnt_seen), 0);
      end
      cyc();
      chk("p36_gnt_after", 32'(gnt_seen), 1);

      // Random pixel demand up to the read of address 100, then vs rises
      vs = 1'b0;
      wr_mode = 2;
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         pix_req = ($urandom_range(0, 3) != 0);
         cyc();
         if (last_rd_addr == 100) found = 1;
      end
      chk("p39_found_rd100", 32'(found), 1);
      vs = 1'b1;
      pix_req = 1'b0;
      cyc();
      cyc();
      chk("p39_next_rd_addr", 32'(last_rd_addr), 0);
      repeat (4) cyc();
      pix_req = 1'b1;
      cyc();
      chk("p39_first_pix", 32'(last_pix), 32'(pat(0)));
      repeat (20) cyc();
      pix_req = 1'b0;

      // Two lines of steady active video
      vs = 1'b0; cyc();
      vs = 1'b1; cyc();
      repeat (20) cyc();
      popped = 0;
      for (int l = 0; l < 2; l++) begin
         for (int c = 0; c < 800; c++) begin
            pix_req = (c < 640);
            cyc();
         end
      end
      pix_req = 1'b0;
      chk("p37_pix_count", popped, 1280);
      chk("p37_underflow", 32'(uf_b), 0);

      // 32-pixel frame: fetch completes, then writer granted until the next vs edge
      vs = 1'b0; cyc();
      s_reads = 0;
      vs = 1'b1; cyc();
      for (int i = 0; i < 300; i++) begin
         pix_req = 1'($urandom_range(0, 1));
         cyc();
      end
      pix_req = 1'b0;
      chk("p40_read_count", s_reads, FPS);
      chk("p40_last_addr", s_last_addr, FPS - 1);
      chk("p40_idle_long", 32'(s_idle >= 100), 1);
      vs = 1'b0; cyc();
      vs = 1'b1; cyc();
      cyc();
      chk("p40_restart_addr", 32'(s_last_rd), 0);

      // Reset in the middle of a fetch: in-flight data must not surface afterwards
      vs = 1'b0; cyc();
      vs = 1'b1; cyc();
      repeat (5) cyc();
      wr_mode = 1;
      wr_req  = 1'b1;
      rstn    = 1'b0;
      vs      = 1'b0;
      repeat (3) cyc();
      rstn = 1'b1;
      repeat (8) cyc();
      pix_req = 1'b1;
      cyc();
      chk("p32_pix_after_rst", 32'(last_pix), 0);
      pix_req = 1'b0;
      cyc();
      chk("p29_underflow", 32'(uf_b), 1);

      // Pixel demand right after a frame start underflows and sticks across vs edges
      rstn = 1'b0;
      cyc(); cyc();
      rstn = 1'b1;
      wr_mode = 2;
      cyc();
      chk("p38_uf_clear", 32'(uf_b), 0);
      vs = 1'b1; cyc();
      pix_req = 1'b1;
      cyc();
      chk("p38_pix_zero", 32'(last_pix), 0);
      pix_req = 1'b0;
      chk("p38_uf_set", 32'(uf_b), 1);
      for (int i = 0; i < 30; i++) begin
         vs = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
         cyc();
      end
      chk("p38_uf_hold", 32'(uf_b), 1);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
